// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge port between the memory stage and the memory.
interface mem_stage_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [3:0]            mem_be;
  logic [31:0]           mem_wdata;
  logic                  mem_ack;
  logic [31:0]           mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: lane steering, load extraction, misalignment
// detection, request/ack handshake with timeout, and the MEM/WB register.
module mem_stage #(
  parameter int ADDR_WIDTH = 32,
  parameter int WAIT_LIMIT = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [31:0] in_result,
  input  logic [31:0] in_store_data,
  input  logic        in_load,
  input  logic        in_store,
  input  logic [1:0]  in_ls_size,
  input  logic        in_ls_unsigned,
  input  logic [4:0]  in_dest_reg,
  input  logic        in_dest_reg_valid,
  mem_stage_if.master mem,
  output logic [31:0] wb_result,
  output logic [4:0]  wb_dest_reg,
  output logic        wb_dest_reg_valid,
  output logic        addr_err,
  output logic        mem_timeout,
  output logic        stall
);

  localparam int CNT_W    = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
  localparam int LIMIT_M1 = (WAIT_LIMIT == 0) ? 0 : WAIT_LIMIT - 1;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t     state, next_state;
  logic [CNT_W-1:0] wait_cnt;

  logic        is_load, mem_op, aligned, access, misaligned;
  logic        req, timeout_now;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data;

  // A store wins when both load and store are flagged.
  assign is_load = in_load & ~in_store;
  assign mem_op  = in_valid & (in_load | in_store);

  always_comb begin
    unique case (in_ls_size)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~in_result[0];
      default: aligned = (in_result[1:0] == 2'b00);
    endcase
  end

  assign access     = mem_op & aligned;
  assign misaligned = mem_op & ~aligned;

  always_comb begin
    mem.mem_be    = 4'b1111;
    mem.mem_wdata = in_store_data;
    unique case (in_ls_size)
      2'b00: begin
        mem.mem_be    = 4'b0001 << in_result[1:0];
        mem.mem_wdata = {4{in_store_data[7:0]}};
      end
      2'b01: begin
        mem.mem_be    = in_result[1] ? 4'b1100 : 4'b0011;
        mem.mem_wdata = {2{in_store_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign mem.mem_addr = {in_result[ADDR_WIDTH-1:2], 2'b00};

  assign ld_byte = 8'(mem.mem_rdata >> {in_result[1:0], 3'b000});
  assign ld_half = in_result[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];

  always_comb begin
    unique case (in_ls_size)
      2'b00:   load_data = {{24{~in_ls_unsigned & ld_byte[7]}}, ld_byte};
      2'b01:   load_data = {{16{~in_ls_unsigned & ld_half[15]}}, ld_half};
      default: load_data = mem.mem_rdata;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= next_state;
      wait_cnt <= (state == WAIT && next_state == WAIT) ? wait_cnt + 1'b1 : '0;
    end
  end

  // On timeout the stall is released so the abandoned instruction retires as a bubble.
  always_comb begin
    next_state  = state;
    req         = 1'b0;
    stall       = 1'b0;
    timeout_now = 1'b0;
    unique case (state)
      IDLE: begin
        req = access;
        if (access && !mem.mem_ack) begin
          stall      = 1'b1;
          next_state = WAIT;
        end
      end
      WAIT: begin
        req = 1'b1;
        if (mem.mem_ack) begin
          next_state = IDLE;
        end else if (WAIT_LIMIT != 0 && wait_cnt == CNT_W'(LIMIT_M1)) begin
          timeout_now = 1'b1;
          next_state  = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
    req   = req & reset_n;
    stall = stall & reset_n;
  end

  assign mem.mem_req = req;
  assign mem.mem_we  = req & in_store;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wb_result         <= '0;
      wb_dest_reg       <= '0;
      wb_dest_reg_valid <= 1'b0;
      addr_err          <= 1'b0;
      mem_timeout       <= 1'b0;
    end else begin
      addr_err    <= misaligned & ~stall;
      mem_timeout <= timeout_now;
      if (stall) begin
        wb_dest_reg_valid <= 1'b0;
      end else begin
        wb_dest_reg       <= in_dest_reg;
        wb_result         <= is_load ? load_data : in_result;
        wb_dest_reg_valid <= in_valid & in_dest_reg_valid & ~in_store
                             & ~misaligned & ~timeout_now;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases followed by randomized
// accesses checked against an arithmetic reference model of the stage.
module tb_mem_stage;

  localparam int LIMIT = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid, in_load, in_store, in_ls_unsigned, in_dest_reg_valid;
  logic [31:0] in_result, in_store_data;
  logic [1:0]  in_ls_size;
  logic [4:0]  in_dest_reg;
  logic [31:0] wb_result;
  logic [4:0]  wb_dest_reg;
  logic        wb_dest_reg_valid, addr_err, mem_timeout, stall;

  int errors = 0;
  int checks = 0;

  mem_stage_if #(.ADDR_WIDTH(32)) mem ();

  mem_stage #(.ADDR_WIDTH(32), .WAIT_LIMIT(LIMIT)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_result(in_result), .in_store_data(in_store_data),
    .in_load(in_load), .in_store(in_store), .in_ls_size(in_ls_size),
    .in_ls_unsigned(in_ls_unsigned), .in_dest_reg(in_dest_reg),
    .in_dest_reg_valid(in_dest_reg_valid), .mem(mem.master),
    .wb_result(wb_result), .wb_dest_reg(wb_dest_reg),
    .wb_dest_reg_valid(wb_dest_reg_valid), .addr_err(addr_err),
    .mem_timeout(mem_timeout), .stall(stall)
  );

  always #5 clock = ~clock;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] model_be(input logic [31:0] addr, input logic [1:0] size);
    if (size == 2'd0) return 4'(1 << (addr % 4));
    if (size == 2'd1) return 4'(3 << (addr & 2));
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] data, input logic [1:0] size);
    if (size == 2'd0) return (data & 32'hFF) * 32'h0101_0101;
    if (size == 2'd1) return (data & 32'hFFFF) * 32'h0001_0001;
    return data;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [31:0] addr,
                                             input logic [1:0] size, input logic uns);
    logic [31:0] v;
    if (size == 2'd0) begin
      v = (rdata >> (8 * (addr % 4))) & 32'hFF;
      if (!uns && v >= 32'd128) v = v + 32'hFFFF_FF00;
    end else if (size == 2'd1) begin
      v = (rdata >> (8 * (addr & 2))) & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v + 32'hFFFF_0000;
    end else begin
      v = rdata;
    end
    return v;
  endfunction

  // One instruction through the stage; delay = cycles before ack (no ack if beyond LIMIT).
  task automatic apply_stimulus(input logic vld, input logic [31:0] addr, input logic [31:0] data,
                                input logic ld, input logic st, input logic [1:0] size,
                                input logic uns, input logic [4:0] dest, input logic dv,
                                input logic [31:0] rdata, input int delay);
    logic op, al, acc, mis, tmo, exp_v;
    int   n_stall;
    op  = vld & (ld | st);
    al  = (size == 2'd0) || (size == 2'd1 && addr % 2 == 0) || (size >= 2'd2 && addr % 4 == 0);
    acc = op & al;
    mis = op & ~al;
    tmo = acc && (delay > LIMIT);
    n_stall = acc ? ((delay < LIMIT) ? delay : LIMIT) : 0;
    in_valid = vld; in_result = addr; in_store_data = data; in_load = ld; in_store = st;
    in_ls_size = size; in_ls_unsigned = uns; in_dest_reg = dest; in_dest_reg_valid = dv;
    mem.mem_rdata = rdata;
    for (int k = 0; k <= n_stall; k++) begin
      mem.mem_ack = (k == delay);
      @(negedge clock);
      check_output("mem_req", 32'(mem.mem_req), 32'(acc));
      check_output("stall", 32'(stall), 32'(k < n_stall));
      if (acc && k == 0) begin
        check_output("mem_we", 32'(mem.mem_we), 32'(st));
        check_output("mem_be", 32'(mem.mem_be), 32'(model_be(addr, size)));
        check_output("mem_addr", mem.mem_addr, addr & 32'hFFFF_FFFC);
        if (st) check_output("mem_wdata", mem.mem_wdata, model_wdata(data, size));
      end
      @(posedge clock); #1;
      if (k < n_stall) check_output("wb_valid_bubble", 32'(wb_dest_reg_valid), 32'd0);
    end
    exp_v = vld & dv & ~st & ~mis & ~tmo;
    check_output("wb_dest_reg_valid", 32'(wb_dest_reg_valid), 32'(exp_v));
    check_output("addr_err", 32'(addr_err), 32'(mis));
    check_output("mem_timeout", 32'(mem_timeout), 32'(tmo));
    if (exp_v) begin
      check_output("wb_dest_reg", 32'(wb_dest_reg), 32'(dest));
      check_output("wb_result", wb_result,
                   (ld && !st) ? model_load(rdata, addr, size, uns) : addr);
    end
    mem.mem_ack = 1'b0;
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0; mem.mem_ack = 1'b0;
    @(negedge clock);
    check_output("idle_mem_req", 32'(mem.mem_req), 32'd0);
    check_output("idle_stall", 32'(stall), 32'd0);
    @(posedge clock); #1;
    check_output("idle_addr_err", 32'(addr_err), 32'd0);
    check_output("idle_mem_timeout", 32'(mem_timeout), 32'd0);
    check_output("idle_wb_valid", 32'(wb_dest_reg_valid), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    in_valid = 1'b1; in_result = 32'h100; in_store_data = 32'h0; in_load = 1'b1;
    in_store = 1'b0; in_ls_size = 2'd2; in_ls_unsigned = 1'b0; in_dest_reg = 5'd1;
    in_dest_reg_valid = 1'b1; mem.mem_ack = 1'b0; mem.mem_rdata = 32'h0;
    repeat (2) @(posedge clock);
    #1;
    check_output("rst_mem_req", 32'(mem.mem_req), 32'd0);
    check_output("rst_stall", 32'(stall), 32'd0);
    check_output("rst_wb_result", wb_result, 32'd0);
    check_output("rst_wb_valid", 32'(wb_dest_reg_valid), 32'd0);
    reset_n = 1'b1;

    apply_stimulus(1, 32'h100, 32'hDEADBEEF, 0, 1, 2'd2, 0, 5'd0, 0, 32'h0, 0);
    apply_stimulus(1, 32'h203, 32'h0, 1, 0, 2'd0, 0, 5'd5, 1, 32'h80112233, 0);
    check_output("sbyte_value", wb_result, 32'hFFFF_FF80);
    apply_stimulus(1, 32'h203, 32'h0, 1, 0, 2'd0, 1, 5'd5, 1, 32'h80112233, 0);
    check_output("ubyte_value", wb_result, 32'h0000_0080);
    apply_stimulus(1, 32'h102, 32'h1234ABCD, 0, 1, 2'd1, 0, 5'd0, 0, 32'h0, 1);
    apply_stimulus(1, 32'h101, 32'h0, 1, 0, 2'd1, 0, 5'd7, 1, 32'h0, 0);
    idle_cycle();
    apply_stimulus(1, 32'h300, 32'h0, 1, 0, 2'd2, 0, 5'd9, 1, 32'hCAFEF00D, 3);
    apply_stimulus(1, 32'h304, 32'h0, 1, 0, 2'd2, 0, 5'd9, 1, 32'h11111111, 20);
    idle_cycle();

    // Reset pulled in the middle of an outstanding access.
    in_valid = 1'b1; in_result = 32'h400; in_load = 1'b1; in_store = 1'b0;
    in_ls_size = 2'd2; mem.mem_ack = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    check_output("rstw_mem_req", 32'(mem.mem_req), 32'd0);
    check_output("rstw_stall", 32'(stall), 32'd0);
    check_output("rstw_wb_result", wb_result, 32'd0);
    check_output("rstw_wb_dest_reg", 32'(wb_dest_reg), 32'd0);
    check_output("rstw_wb_valid", 32'(wb_dest_reg_valid), 32'd0);
    in_load = 1'b0; mem.mem_ack = 1'b1;
    @(posedge clock); #1;
    reset_n = 1'b1;
    apply_stimulus(1, 32'h42, 32'h0, 0, 0, 2'd2, 0, 5'd3, 1, 32'h0, 0);
    check_output("alu_after_reset", wb_result, 32'h42);

    for (int i = 0; i < 60; i++) begin
      logic [1:0]  kind;
      int          dly;
      kind = 2'($urandom_range(0, 3));
      dly  = ($urandom_range(0, 7) == 0) ? 9 : int'($urandom_range(0, 4));
      apply_stimulus(1'($urandom_range(0, 9) != 0), $urandom, $urandom,
                     kind[0], kind[1], 2'($urandom), 1'($urandom), 5'($urandom),
                     1'($urandom), $urandom, dly);
      if (i % 4 == 3) idle_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the execute stage.
- Takes the EX/MEM pipeline register contents (ALU result/address, store data, load/store control, destination register) and drives a request/acknowledge data-memory port.
- Performs byte-lane steering, load extraction and sign/zero extension, and misalignment detection.
- Registers the MEM/WB result that execute forwards from (`result_from_mem_wb`); asserts `stall` while a memory access is outstanding.

Parameters:
- `ADDR_WIDTH`, 32, width of `mem_addr`; taken from the low bits of `in_result`.
- `WAIT_LIMIT`, 255, maximum WAIT cycles before `mem_timeout` pulses; 0 disables the timeout.

Ports:
- `clock` input 1: clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: EX/MEM register holds a live instruction.
- `in_result` input 32: ALU result; this is the effective address for loads and stores.
- `in_store_data` input 32: store data (`result_2` of execute).
- `in_load` input 1: load instruction.
- `in_store` input 1: store instruction.
- `in_ls_size` input 2: access size; 00 byte, 01 half, 10 word, 11 treated as word.
- `in_ls_unsigned` input 1: zero-extend loads.
- `in_dest_reg` input 5: destination register.
- `in_dest_reg_valid` input 1: destination register is written.
- `mem_req` output 1: memory request.
- `mem_we` output 1: write enable.
- `mem_addr` output `ADDR_WIDTH`: word-aligned address, low 2 bits forced to 0.
- `mem_be` output 4: byte enables; bit i = byte lane i, little-endian.
- `mem_wdata` output 32: lane-replicated store data.
- `mem_ack` input 1: access complete; `mem_rdata` is valid in the same cycle.
- `mem_rdata` input 32: read data.
- `wb_result` output 32: registered MEM/WB result.
- `wb_dest_reg` output 5: registered destination register.
- `wb_dest_reg_valid` output 1: registered write enable.
- `addr_err` output 1: registered one-cycle misalignment pulse.
- `mem_timeout` output 1: registered one-cycle timeout pulse.
- `stall` output 1: holds the upstream pipeline.

Behaviour:
- Reset: asynchronous, active-low. State = IDLE. `wb_result`=0, `wb_dest_reg`=0, `wb_dest_reg_valid`=0, `addr_err`=0, `mem_timeout`=0, wait counter = 0. `mem_req` is forced 0 while `reset_n` is low.
- access = `in_valid` & (`in_load` | `in_store`) & aligned. If `in_load` and `in_store` are both set, `in_load` is ignored.
- Aligned means: half requires `addr[0]`=0; word requires `addr[1:0]`=0; byte is always aligned.
- Lane steering:
  - byte: `mem_be` = 1<<`addr[1:0]`, `mem_wdata` = {4{data[7:0]}}.
  - half: `mem_be` = 0011 if `addr[1]`=0 else 1100, `mem_wdata` = {2{data[15:0]}}.
  - word: `mem_be` = 1111, `mem_wdata` = data.
- Loads drive the same `mem_be` with `mem_we`=0.
- Load extraction: select byte `addr[1:0]` or half `addr[1]` from `mem_rdata`, then sign- or zero-extend per `in_ls_unsigned`. Word loads pass `mem_rdata` unchanged.
- FSM, two states:
  - IDLE: `mem_req` = access, combinational; no registered request cycle. If access & `mem_ack`, the access completes in this cycle (zero-wait) and state stays IDLE. If access & ~`mem_ack`, next state = WAIT.
  - WAIT: `mem_req`=1. Address, data and controls are held stable by upstream stall. On `mem_ack`, next state = IDLE.
- `stall` = (IDLE & access & ~`mem_ack`) | (WAIT & ~`mem_ack`).
- `mem_ack` while `mem_req`=0 is ignored.
- WB register update, every cycle:
  - If `stall`: `wb_dest_reg_valid` <= 0 (bubble); `wb_result` and `wb_dest_reg` hold.
  - Else: `wb_dest_reg` <= `in_dest_reg`. `wb_result` <= extracted load data for a load, otherwise `in_result`.
  - Else (cont.): `wb_dest_reg_valid` <= `in_valid` & `in_dest_reg_valid` & ~store & ~misaligned.
- Misaligned load or store with `in_valid`:
  - No request is issued, no stall occurs, the destination write is suppressed.
  - `addr_err` <= 1 for one cycle; `addr_err` <= 0 otherwise.
- Timeout: the wait counter increments each WAIT cycle and clears on leaving WAIT. If `WAIT_LIMIT`≠0 and the counter reaches `WAIT_LIMIT` without `mem_ack`:
  - `mem_timeout` pulses for one cycle, state -> IDLE, `mem_req` drops.
  - The instruction completes with `wb_dest_reg_valid`=0.
- Latency: non-memory instructions and zero-wait accesses take 1 cycle to the WB register. An N-wait access stalls N cycles.
- `reset_n` asserted during WAIT: state returns to IDLE immediately and `mem_req` drops asynchronously. The outstanding access is abandoned and any later `mem_ack` is ignored.

Test Plan:
- Word store, `in_result`=0x100, data=0xDEADBEEF, `mem_ack` same cycle -> `mem_req`=1, `mem_we`=1, `mem_be`=1111, `mem_addr`=0x100, `stall`=0 throughout, `wb_dest_reg_valid`=0 next cycle.
- Signed byte load, addr=0x203, `mem_rdata`=0x80112233, dest=5 -> `mem_be`=1000, `wb_result`=0xFFFFFF80, `wb_dest_reg`=5, `wb_dest_reg_valid`=1. Repeat with `in_ls_unsigned`=1 -> `wb_result`=0x00000080.
- Half store, addr=0x102, data=0x1234ABCD -> `mem_be`=1100, `mem_wdata`=0xABCDABCD.
- Half load at addr=0x101 -> `mem_req` stays 0, `stall`=0, `addr_err`=1 for exactly one cycle, `wb_dest_reg_valid`=0.
- Word load with `mem_ack` after 3 cycles -> `stall`=1 for 3 cycles, `wb_dest_reg_valid`=0 on those cycles, then `wb_result`=`mem_rdata`. `WAIT_LIMIT`=4 with no ack -> `mem_timeout` pulses, FSM returns to IDLE.
- Assert `reset_n` low while in WAIT -> `mem_req`=0 immediately, all outputs at reset values. A following ack-free ALU op (`in_result`=0x42, dest=3) -> `wb_result`=0x42 after 1 cycle.
